// File: rtl/irq_event_coalescer_pkg.sv
// Shared definitions for the IRQ event coalescer: channel FSM states and source limits.
package irq_event_coalescer_pkg;

    localparam int IRQ_MAX = 32;

    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_ACCUM = 1'b1
    } chan_state_t;

endpackage

// File: rtl/irq_coalesce_chan.sv
// One coalescing channel: edge detect, saturating event accumulator, holdoff timer,
// IDLE/ACCUM FSM and a registered single-cycle strobe.
module irq_coalesce_chan
    import irq_event_coalescer_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMER_W = 24
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               armed,
    input  logic               sync_in,
    input  logic               enable,
    input  logic [CNT_W-1:0]   threshold,
    input  logic [TIMER_W-1:0] timeout,
    output logic               irq,
    output logic [CNT_W-1:0]   accum
);

    chan_state_t        state, state_n;
    logic               sync_d, evt_edge;
    logic [CNT_W-1:0]   accum_n, accum_inc, eff_thresh;
    logic [TIMER_W-1:0] timer, timer_n, timer_dec;
    logic               fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
        if (inc && (a != {CNT_W{1'b1}}))
            return a + CNT_W'(1);
        return a;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_d   <= 1'b0;
            evt_edge <= 1'b0;
        end else begin
            sync_d   <= sync_in;
            evt_edge <= armed & sync_in & ~sync_d;
        end
    end

    assign eff_thresh = (threshold == '0) ? CNT_W'(1) : threshold;
    assign timer_dec  = (timer != '0) ? timer - TIMER_W'(1) : '0;
    assign accum_inc  = sat_inc(accum, evt_edge);

    // Timeout fires when the decremented timer reaches 1, so the strobe lands
    // exactly cfg_timeout cycles after the edge that opened the batch.
    always_comb begin
        state_n = state;
        accum_n = accum;
        timer_n = timer;
        fire    = 1'b0;
        if (!enable) begin
            state_n = CH_IDLE;
            accum_n = '0;
            timer_n = '0;
        end else begin
            case (state)
                CH_IDLE: begin
                    if (evt_edge) begin
                        accum_n = CNT_W'(1);
                        timer_n = timeout;
                        if ((eff_thresh == CNT_W'(1)) || (timeout == TIMER_W'(1))) begin
                            fire    = 1'b1;
                            accum_n = '0;
                            timer_n = '0;
                        end else begin
                            state_n = CH_ACCUM;
                        end
                    end
                end
                CH_ACCUM: begin
                    accum_n = accum_inc;
                    timer_n = timer_dec;
                    if ((accum_inc >= eff_thresh) ||
                        ((timer != '0) && (timer_dec == TIMER_W'(1)))) begin
                        fire    = 1'b1;
                        accum_n = '0;
                        timer_n = '0;
                        state_n = CH_IDLE;
                    end
                end
                default: state_n = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= CH_IDLE;
            accum <= '0;
            timer <= '0;
            irq   <= 1'b0;
        end else begin
            state <= state_n;
            accum <= accum_n;
            timer <= timer_n;
            irq   <= fire;
        end
    end

endmodule

// File: rtl/irq_event_coalescer.sv
// Front end for the interrupt manager: synchronises raw event lines and feeds one
// coalescing channel per source; edges stay disarmed briefly after reset release.
module irq_event_coalescer
    import irq_event_coalescer_pkg::*;
#(
    parameter int IRQ_COUNT   = 1,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TIMER_W     = 24
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [IRQ_COUNT-1:0] evt_in,
    input  logic [IRQ_COUNT-1:0] cfg_enable,
    input  logic [CNT_W-1:0]     cfg_threshold,
    input  logic [TIMER_W-1:0]   cfg_timeout,
    output logic [IRQ_COUNT-1:0] irq_out,
    output logic [CNT_W-1:0]     dbg_accum0
);

    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    logic [IRQ_COUNT-1:0] sync_q [SYNC_STAGES];
    logic [ARM_W-1:0]     arm_cnt;
    logic                 armed;
    logic [CNT_W-1:0]     accum_all [IRQ_COUNT];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
        end else begin
            sync_q[0] <= evt_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    // A line already high at reset release fills the synchroniser while disarmed,
    // so its apparent rising edge is never seen as an event.
    assign armed = (arm_cnt == ARM_W'(ARM_CYCLES));

    always_ff @(posedge clk) begin
        if (!resetn)
            arm_cnt <= '0;
        else if (!armed)
            arm_cnt <= arm_cnt + ARM_W'(1);
    end

    for (genvar k = 0; k < IRQ_COUNT; k++) begin : g_chan
        irq_coalesce_chan #(
            .CNT_W   (CNT_W),
            .TIMER_W (TIMER_W)
        ) u_chan (
            .clk       (clk),
            .resetn    (resetn),
            .armed     (armed),
            .sync_in   (sync_q[SYNC_STAGES-1][k]),
            .enable    (cfg_enable[k]),
            .threshold (cfg_threshold),
            .timeout   (cfg_timeout),
            .irq       (irq_out[k]),
            .accum     (accum_all[k])
        );
    end

    assign dbg_accum0 = accum_all[0];

endmodule
